// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - command codes and FSM state type for the SPI register-file responder
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } spi_slv_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - two-flop synchronizer with rise/fall detect for one asynchronous pin
module spi_pin_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to 0 so a chip select held low across reset never looks like a new falling edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regfile.sv
// rtl/spi_slave_regfile.sv - SPI mode-0 responder over a byte register file, oversampled in clk_i
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          spi_sck_i,
  input  logic          spi_csn_i,
  input  logic          spi_sdi_i,
  output logic          spi_sdo_o,
  output logic          spi_sdo_oe_o,
  output logic          busy_o,
  output logic          wr_valid_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic csn_level, csn_fall, csn_rise_unused;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;

  spi_pin_sync u_sck (.clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_sck_i),
                      .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall));
  spi_pin_sync u_csn (.clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_csn_i),
                      .level_o(csn_level), .rise_o(csn_rise_unused), .fall_o(csn_fall));
  spi_pin_sync u_sdi (.clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_sdi_i),
                      .level_o(sdi_level), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused));

  spi_slv_state_e state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [6:0]    shift_in_q;
  logic [6:0]    shift_out_q;
  logic          sdo_q;
  logic [AW-1:0] addr_q;
  logic          is_read_q;
  logic [7:0]    mem [DEPTH];

  logic       shifting;
  logic       byte_done;
  logic [7:0] rx_byte;

  assign shifting  = sck_rise && (state_q inside {CMD, ADDR, WDATA, RDATA});
  assign byte_done = shifting && (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_in_q, sdi_level};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (csn_level) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (csn_fall) state_d = CMD;
        CMD:  if (byte_done) state_d = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
        ADDR: if (byte_done) state_d = is_read_q ? RDATA : WDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    spi_sdo_oe_o = (state_q == RDATA);
  end

  assign spi_sdo_o = sdo_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      sdo_q       <= 1'b0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      rd_data_o   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      rd_data_o  <= mem[rd_addr_i];
      if (state_q == IDLE) begin
        bit_cnt_q <= '0;
        sdo_q     <= 1'b0;
      end
      if (shifting) begin
        shift_in_q <= rx_byte[6:0];
        bit_cnt_q  <= bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        case (state_q)
          CMD:  is_read_q <= (rx_byte == CMD_READ);
          ADDR: addr_q    <= rx_byte[AW-1:0];
          WDATA: begin
            mem[addr_q] <= rx_byte;
            wr_valid_o  <= 1'b1;
            wr_addr_o   <= addr_q;
            wr_data_o   <= rx_byte;
            addr_q      <= addr_q + AW'(1);
          end
          RDATA: addr_q <= addr_q + AW'(1);
          default: ;
        endcase
      end
      // A fall with the counter at zero starts a byte: load it late so same-frame writes are visible.
      if (sck_fall && state_q == RDATA) begin
        if (bit_cnt_q == 3'd0) {sdo_q, shift_out_q} <= mem[addr_q];
        else                   {sdo_q, shift_out_q} <= {shift_out_q, 1'b0};
      end
    end
  end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

Synthesizable SPI mode-0 responder with a small byte-addressed register file, the far end of the SoC SPI master port (`spi_master_clk_o`/`csn0_o`/`sdo0_o`/`sdi0_i`). All pins are oversampled in `clk_i`; no logic runs on SCK. Firmware tests write bytes through the SPI master, and the bench or on-chip checker reads them back over a local port. Reads over SPI return the stored bytes.

## Interface
- `DEPTH`, 16: number of 8-bit registers; power of two, 2..256.
- `AW`, $clog2(DEPTH): register address width (derived, not overridden).

- `clk_i` in 1: system clock; must be ≥ 4× SCK frequency.
- `rst_i` in 1: reset, synchronous, active-high.
- `spi_sck_i` in 1: SPI clock (asynchronous).
- `spi_csn_i` in 1: chip select, active-low (asynchronous).
- `spi_sdi_i` in 1: MOSI (asynchronous).
- `spi_sdo_o` out 1: MISO.
- `spi_sdo_oe_o` out 1: MISO output enable (high only in RDATA).
- `busy_o` out 1: transaction in progress (state ≠ IDLE).
- `wr_valid_o` out 1: one-cycle pulse per committed SPI write byte.
- `wr_addr_o` out AW: address of committed byte.
- `wr_data_o` out 8: committed byte.
- `rd_addr_i` in AW: local read address.
- `rd_data_o` out 8: local read data, registered.

## Operation
- Frame: CMD byte, ADDR byte, then data bytes until CSN rises. MSB first. Sample on SCK rise, shift out on SCK fall.
- CMD 0x02 selects write. CMD 0x03 selects read. Any other value goes to IGNORE.
- ADDR byte: the low AW bits are used and the upper bits are ignored.
- States and transitions:
  - IDLE → CMD on the CSN falling edge (synchronized). The bit counter is cleared.
  - CMD → WDATA, RDATA or IGNORE after the 8th bit. For 0x02 and 0x03, the next state is ADDR first, then WDATA or RDATA.
  - ADDR → WDATA or RDATA after the 8th bit.
  - WDATA: each completed byte is written to `mem[addr]`. `wr_valid_o` pulses. The address increments modulo DEPTH (wrap DEPTH-1 → 0).
  - RDATA: `mem[addr]` is loaded into the shift register at byte start. The address increments after the 8th rising edge.
  - IGNORE: shifts nothing. `spi_sdo_oe_o` = 0.
  - Any state → IDLE when synchronized CSN is high. Partial bytes are discarded with no write and no pulse.
- Read/write hazard: if a read byte addresses a register written earlier in the same frame, it returns the new value.
- Local port: `rd_data_o` is `mem[rd_addr_i]` registered one cycle later. If an SPI commit hits the same address in the same cycle, the old value is returned.
- Reset: all registers in `mem` = 0x00, state IDLE, counters 0.

## Timing
- Pin path: 2-flop synchronizer, then 1 edge-detect flop. An SCK edge is seen 3 `clk_i` cycles after the pin changes.
- A write commit (`mem`, `wr_*` outputs) happens 1 `clk_i` after the 8th detected SCK rise of a data byte.
- RDATA MSB: `spi_sdo_o` updates 1 `clk_i` after the detected SCK fall that follows the last ADDR bit. Later bits update 1 `clk_i` after each detected fall. The value is stable for ≥ 1 SCK half-period before the sampling rise.
- Output reset values:
  - `spi_sdo_o` = 0, `spi_sdo_oe_o` = 0, `busy_o` = 0
  - `wr_valid_o` = 0, `wr_addr_o` = 0, `wr_data_o` = 0, `rd_data_o` = 0
- `rst_i` mid-frame: the next cycle is IDLE with outputs at reset values. The remainder of the frame is treated as IGNORE until CSN rises and falls again (no IDLE→CMD without a new CSN fall).
- `spi_sdo_oe_o` drops 1 `clk_i` after synchronized CSN rises.

## Structure
- Package `spi_slave_pkg` contains:
  - `CMD_WRITE` = 8'h02, `CMD_READ` = 8'h03
  - state enum `spi_slv_state_e` {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE}
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus rise/fall detect for one pin. Instantiated for SCK, CSN and SDI (SDI uses synchronized data only).
- Top level: FSM, 3-bit bit counter, 8-bit shift registers, AW-bit address counter, DEPTH×8 flop array.

## Test plan
- Write burst: CMD 0x02, ADDR 0x03, data 0xA5 0x5A → `wr_valid_o` pulses twice (addr 3/0xA5, addr 4/0x5A). Local reads of 3 and 4 return 0xA5 and 0x5A one cycle later.
- Read burst after the above: CMD 0x03, ADDR 0x03, two bytes → MISO shows 0xA5 then 0x5A. `spi_sdo_oe_o` is high only during the data bytes.
- Wrap: write ADDR 0x0F, data 0x11 0x22 (DEPTH=16) → mem[15] = 0x11, mem[0] = 0x22. ADDR 0xF3 is treated as address 3.
- Abort: CMD 0x02, ADDR 0x05, 5 bits of 0xFF, then CSN high → no `wr_valid_o`, mem[5] unchanged, `busy_o` = 0 within 4 `clk_i`.
- Bad command 0x9F followed by 3 bytes → no writes, `spi_sdo_oe_o` stays 0. The next valid frame works normally.
- Reset mid-write after the ADDR byte → all outputs at reset values and mem cleared. The rest of the frame is ignored. A new frame with CMD 0x03, ADDR 0x00 returns 0x00.
